// File: rtl/sap_ctrl_seq_pkg.sv
// Shared definitions for the SAP controller-sequencer: opcodes, T-state indices
// and the control-word layout.
package sap_ctrl_seq_pkg;

  typedef enum logic [3:0] {
    OP_LDA = 4'h0,
    OP_ADD = 4'h1,
    OP_SUB = 4'h2,
    OP_JMP = 4'h3,
    OP_JZ  = 4'h4,
    OP_NOP = 4'h5,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } op_e;

  localparam int T1 = 0;
  localparam int T2 = 1;
  localparam int T3 = 2;
  localparam int T4 = 3;
  localparam int T5 = 4;
  localparam int T6 = 5;

  typedef struct packed {
    logic cp;
    logic ep;
    logic n_lm;
    logic n_ce;
    logic n_l1;
    logic n_e1;
    logic n_la;
    logic ea;
    logic su;
    logic eu;
    logic n_lb;
    logic n_l0;
    logic lp;
    logic n_hlt;
  } ctrl_word_t;

  localparam ctrl_word_t CW_IDLE = '{
    cp: 1'b0, ep: 1'b0, n_lm: 1'b1, n_ce: 1'b1, n_l1: 1'b1, n_e1: 1'b1,
    n_la: 1'b1, ea: 1'b0, su: 1'b0, eu: 1'b0, n_lb: 1'b1, n_l0: 1'b1,
    lp: 1'b0, n_hlt: 1'b1
  };

  // Any opcode with non-zero upper bits, or an unlisted low nibble, is a NOP.
  function automatic op_e decode_op(input logic [3:0] lo, input logic hi_zero);
    if (!hi_zero) return OP_NOP;
    case (lo)
      4'h0:    return OP_LDA;
      4'h1:    return OP_ADD;
      4'h2:    return OP_SUB;
      4'h3:    return OP_JMP;
      4'h4:    return OP_JZ;
      4'hE:    return OP_OUT;
      4'hF:    return OP_HLT;
      default: return OP_NOP;
    endcase
  endfunction

endpackage

// File: rtl/sap_ctrl_seq_ring.sv
// One-hot T-state ring: advances each clock unless held or halted; wraps to T1
// early on request or naturally after the last position.
module sap_ring_counter #(
  parameter int T_STATES = 6
) (
  input  logic                clk,
  input  logic                n_clr,
  input  logic                hold,
  input  logic                wrap_early,
  input  logic                halt,
  output logic [T_STATES-1:0] ring
);

  localparam logic [T_STATES-1:0] RING_T1 = {{(T_STATES-1){1'b0}}, 1'b1};

  logic [T_STATES-1:0] ring_nxt;
  logic                one_hot;

  assign one_hot = (ring != '0) && ((ring & (ring - 1'b1)) == '0);

  always_comb begin
    ring_nxt = ring;
    if (!one_hot)
      ring_nxt = RING_T1;
    else if (halt || hold)
      ring_nxt = ring;
    else if (wrap_early)
      ring_nxt = RING_T1;
    else
      ring_nxt = {ring[T_STATES-2:0], ring[T_STATES-1]};
  end

  always_ff @(posedge clk) begin
    if (!n_clr) ring <= RING_T1;
    else        ring <= ring_nxt;
  end

endmodule

// File: rtl/sap_ctrl_seq.sv
// SAP controller-sequencer: T-state ring plus opcode decode producing the
// bus control word, with jumps, memory stall, halt and instruction-done strobe.
module sap_ctrl_seq #(
  parameter int OP_W      = 4,
  parameter int T_STATES  = 6,
  parameter bit EARLY_END = 1'b1
) (
  input  logic                clk,
  input  logic                n_clr,
  input  logic [OP_W-1:0]     ir_op,
  input  logic                zero,
  input  logic                mem_rdy,
  output logic [T_STATES-1:0] temp_ring_counter,
  output logic                cp,
  output logic                ep,
  output logic                n_lm,
  output logic                n_ce,
  output logic                n_l1,
  output logic                n_e1,
  output logic                n_la,
  output logic                ea,
  output logic                su,
  output logic                eu,
  output logic                n_lb,
  output logic                n_l0,
  output logic                lp,
  output logic                n_hlt,
  output logic                instr_done
);
  import sap_ctrl_seq_pkg::*;

  logic [T_STATES-1:0] ring;
  op_e                 op;
  logic                mem_op, last, wrap_early;
  logic                halt_now, halt, halt_q, stall;
  ctrl_word_t          cw;

  assign op     = decode_op(ir_op[3:0], (ir_op >> 4) == '0);
  assign mem_op = (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB);

  always_comb begin
    last = 1'b0;
    case (op)
      OP_JMP, OP_JZ, OP_OUT: last = ring[T4];
      OP_HLT:                last = 1'b0;
      default:               last = ring[T6];
    endcase
  end

  assign halt_now   = ring[T4] && (op == OP_HLT);
  assign halt       = halt_q || halt_now;
  assign stall      = !mem_rdy && (ring[T3] || (ring[T5] && mem_op));
  assign wrap_early = EARLY_END && last;

  always_ff @(posedge clk) begin
    if (!n_clr)        halt_q <= 1'b0;
    else if (halt_now) halt_q <= 1'b1;
  end

  sap_ring_counter #(.T_STATES(T_STATES)) u_ring (
    .clk        (clk),
    .n_clr      (n_clr),
    .hold       (stall),
    .wrap_early (wrap_early),
    .halt       (halt),
    .ring       (ring)
  );

  always_comb begin
    cw = CW_IDLE;
    if (ring[T1]) begin
      cw.ep   = 1'b1;
      cw.n_lm = 1'b0;
    end
    if (ring[T2]) cw.cp = 1'b1;
    if (ring[T3]) begin
      cw.n_ce = 1'b0;
      cw.n_l1 = 1'b0;
    end
    if (ring[T4]) begin
      case (op)
        OP_LDA, OP_ADD, OP_SUB: begin
          cw.n_e1 = 1'b0;
          cw.n_lm = 1'b0;
        end
        OP_JMP: begin
          cw.n_e1 = 1'b0;
          cw.lp   = 1'b1;
        end
        OP_JZ: begin
          cw.n_e1 = 1'b0;
          cw.lp   = zero;
        end
        OP_OUT: begin
          cw.ea   = 1'b1;
          cw.n_l0 = 1'b0;
        end
        OP_HLT:  cw.n_hlt = 1'b0;
        default: ;
      endcase
    end
    if (ring[T5] && mem_op) begin
      cw.n_ce = 1'b0;
      if (op == OP_LDA) cw.n_la = 1'b0;
      else              cw.n_lb = 1'b0;
    end
    if (ring[T6] && (op == OP_ADD || op == OP_SUB)) begin
      cw.eu   = 1'b1;
      cw.n_la = 1'b0;
      cw.su   = (op == OP_SUB);
    end
    // Once halted, ignore whatever the IR now holds.
    if (halt_q) begin
      cw       = CW_IDLE;
      cw.n_hlt = 1'b0;
    end
    if (!n_clr) cw = CW_IDLE;
  end

  assign temp_ring_counter = ring;
  assign instr_done = n_clr && !halt && !stall && (wrap_early || ring[T_STATES-1]);

  assign cp    = cw.cp;
  assign ep    = cw.ep;
  assign n_lm  = cw.n_lm;
  assign n_ce  = cw.n_ce;
  assign n_l1  = cw.n_l1;
  assign n_e1  = cw.n_e1;
  assign n_la  = cw.n_la;
  assign ea    = cw.ea;
  assign su    = cw.su;
  assign eu    = cw.eu;
  assign n_lb  = cw.n_lb;
  assign n_l0  = cw.n_l0;
  assign lp    = cw.lp;
  assign n_hlt = cw.n_hlt;

endmodule
